// File: rtl/time_digit_converter.sv
// ---------------------------------------------------------------------------
// time_digit_converter
//
// Converts a snapshot of the time-keeping counters into four BCD digit codes
// for the 7-segment decoders. Two fields are picked by mode, saturated to 99,
// and run through two parallel shift-add-3 (double-dabble) engines, one step
// per clock. The result is registered onto d3..d0 with a one-cycle out_valid.
//
// Parameters
//   FIELD_W   width of each time field input (4..7, default 7)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request to convert hour/min/sec under the given mode
//   in_ready   high while idle; a request is taken when both are high
//   mode       0 = HH:MM, 1 = 00:SS, 2 = MM:SS, 3 = same as 0
//   hour/min/sec  unsigned binary time fields
//   out_valid  one-cycle strobe, d3..d0 and ovf were just updated
//   d3, d2     high/low digit of the left field (0..9, 16 = blank)
//   d1, d0     high/low digit of the right field (0..9)
//   ovf        a selected field exceeded 99 in the last conversion
//
// Build option
//   TIME_DIGIT_BLANK_EN  when defined, leading zeros of the left field are
//                        blanked (code 16) as the outputs load.
// ---------------------------------------------------------------------------
module time_digit_converter #(
  parameter int FIELD_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [FIELD_W-1:0] hour,
  input  logic [FIELD_W-1:0] min,
  input  logic [FIELD_W-1:0] sec,
  output logic               out_valid,
  output logic [4:0]         d3,
  output logic [4:0]         d2,
  output logic [4:0]         d1,
  output logic [4:0]         d0,
  output logic               ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] LAST_STEP = 3'(FIELD_W - 1);
  localparam logic [7:0] SAT_MAX   = 8'd99;
  localparam logic [4:0] BLANK     = 5'd16;

  // Largest representable two-digit value; only reachable when FIELD_W = 7.
  function automatic logic over_range(input logic [FIELD_W-1:0] v);
    return (8'(v) > SAT_MAX);
  endfunction

  function automatic logic [FIELD_W-1:0] sat_field(input logic [FIELD_W-1:0] v);
    if (over_range(v)) begin
      return SAT_MAX[FIELD_W-1:0];
    end
    return v;
  endfunction

  // Double-dabble correction: any nibble of 5 or more would overflow past 9
  // after the next doubling, so pre-add 3 to carry into the next decade.
  function automatic logic [7:0] add3(input logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = b[7:4];
    lo = b[3:0];
    if (hi >= 4'd5) hi = hi + 4'd3;
    if (lo >= 4'd5) lo = lo + 4'd3;
    return {hi, lo};
  endfunction

  logic [1:0]         state;
  logic [2:0]         step;

  logic [FIELD_W-1:0] left_bin;
  logic [FIELD_W-1:0] right_bin;
  logic [7:0]         left_bcd;
  logic [7:0]         right_bcd;
  logic               ovf_flag;
`ifdef TIME_DIGIT_BLANK_EN
  logic [1:0]         mode_r;
`endif

  logic [FIELD_W-1:0] left_sel;
  logic [FIELD_W-1:0] right_sel;
  logic [FIELD_W+7:0] left_shift;
  logic [FIELD_W+7:0] right_shift;
  logic [4:0]         nd3;
  logic [4:0]         nd2;
  logic [4:0]         nd1;
  logic [4:0]         nd0;

  assign in_ready = (state == S_IDLE);

  // Field selection by mode; mode 3 falls into the HH:MM default.
  always_comb begin
    left_sel  = hour;
    right_sel = min;
    case (mode)
      2'd1: begin
        left_sel  = '0;
        right_sel = sec;
      end
      2'd2: begin
        left_sel  = min;
        right_sel = sec;
      end
      default: begin
        left_sel  = hour;
        right_sel = min;
      end
    endcase
  end

  // One double-dabble step: correct the BCD nibbles, then shift the
  // combined {bcd, bin} register left so the next binary MSB enters.
  always_comb begin
    left_shift  = {add3(left_bcd),  left_bin}  << 1;
    right_shift = {add3(right_bcd), right_bin} << 1;
  end

  // Digit codes presented at load time, with optional leading-zero blanking.
  always_comb begin
    nd3 = {1'b0, left_bcd[7:4]};
    nd2 = {1'b0, left_bcd[3:0]};
    nd1 = {1'b0, right_bcd[7:4]};
    nd0 = {1'b0, right_bcd[3:0]};
`ifdef TIME_DIGIT_BLANK_EN
    if (mode_r == 2'd1) begin
      nd3 = BLANK;
      nd2 = BLANK;
    end else if (left_bcd[7:4] == 4'd0) begin
      nd3 = BLANK;
    end
`endif
  end

  // Control: state, step counter, and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step      <= '0;
      out_valid <= 1'b0;
      d3        <= '0;
      d2        <= '0;
      d1        <= '0;
      d0        <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_CONV;
            step  <= '0;
          end
        end
        S_CONV: begin
          if (step == LAST_STEP) begin
            state <= S_DONE;
          end else begin
            step <= step + 3'd1;
          end
        end
        S_DONE: begin
          d3        <= nd3;
          d2        <= nd2;
          d1        <= nd1;
          d0        <= nd0;
          ovf       <= ovf_flag;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: capture on accept, shift while converting.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      left_bin  <= sat_field(left_sel);
      right_bin <= sat_field(right_sel);
      left_bcd  <= '0;
      right_bcd <= '0;
      ovf_flag  <= over_range(left_sel) | over_range(right_sel);
`ifdef TIME_DIGIT_BLANK_EN
      mode_r    <= mode;
`endif
    end else if (state == S_CONV) begin
      left_bcd  <= left_shift[FIELD_W+7:FIELD_W];
      left_bin  <= left_shift[FIELD_W-1:0];
      right_bcd <= right_shift[FIELD_W+7:FIELD_W];
      right_bin <= right_shift[FIELD_W-1:0];
    end
  end

endmodule

// File: tb/tb_time_digit_converter.sv
// ---------------------------------------------------------------------------
// tb_time_digit_converter
//
// Drives directed requests from the test plan followed by a randomized stream
// (random requests, modes, field values and occasional resets). A reference
// model computes digits with divide/modulo and tracks how many cycles remain
// until the result is due; one process compares every DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_time_digit_converter;

  localparam int FW = 7;
`ifdef TIME_DIGIT_BLANK_EN
  localparam int BZ = 16;
`else
  localparam int BZ = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [FW-1:0] hour = '0;
  logic [FW-1:0] min = '0;
  logic [FW-1:0] sec = '0;
  logic          in_ready;
  logic          out_valid;
  logic          ovf;
  logic [4:0]    d3, d2, d1, d0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // model state
  int m_busy = 0;
  int p3 = 0, p2 = 0, p1 = 0, p0 = 0, p_ovf = 0;
  int e3 = 0, e2 = 0, e1 = 0, e0 = 0, e_ovf = 0, e_valid = 0;

  always #5 clk = ~clk;

  time_digit_converter #(.FIELD_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .hour(hour), .min(min), .sec(sec),
    .out_valid(out_valid), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .ovf(ovf)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_convert(input int md, input int h, input int m, input int s,
                               output int o3, output int o2, output int o1,
                               output int o0, output int ov);
    int l, r;
    l  = (md == 1) ? 0 : (md == 2) ? m : h;
    r  = (md == 0 || md == 3) ? m : s;
    ov = (l > 99 || r > 99) ? 1 : 0;
    if (l > 99) l = 99;
    if (r > 99) r = 99;
    o3 = l / 10;
    o2 = l % 10;
    o1 = r / 10;
    o0 = r % 10;
`ifdef TIME_DIGIT_BLANK_EN
    if (md == 1) begin
      o3 = 16;
      o2 = 16;
    end else if (o3 == 0) begin
      o3 = 16;
    end
`endif
  endtask

  // Reference model and per-cycle compare. Inputs change only 1 time unit
  // after the falling edge, so the values seen here are those sampled at the
  // rising edge that just passed.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0;
      e3 = 0; e2 = 0; e1 = 0; e0 = 0; e_ovf = 0; e_valid = 0;
    end else begin
      e_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          e3 = p3; e2 = p2; e1 = p1; e0 = p0; e_ovf = p_ovf;
          e_valid = 1;
        end
      end else if (in_valid) begin
        model_convert(int'(mode), int'(hour), int'(min), int'(sec),
                      p3, p2, p1, p0, p_ovf);
        m_busy = FW + 1;
      end
    end
    chk("out_valid", int'(out_valid), e_valid);
    chk("in_ready", int'(in_ready), (m_busy == 0) ? 1 : 0);
    chk("d3", int'(d3), e3);
    chk("d2", int'(d2), e2);
    chk("d1", int'(d1), e1);
    chk("d0", int'(d0), e0);
    chk("ovf", int'(ovf), e_ovf);
  end

  task automatic req(input int md, input int h, input int m, input int s);
    bit acc;
    acc = 0;
    @(negedge clk); #1;
    mode = 2'(md); hour = FW'(h); min = FW'(m); sec = FW'(s);
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        acc = 1;
        acc_cyc = cyc + 1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("accept_timeout", int'(acc), 1);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_case(input string nm, input int md, input int h, input int m,
                          input int s, input int x3, input int x2, input int x1,
                          input int x0, input int xov);
    bit got;
    got = 0;
    req(md, h, m, s);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_done_timeout"}, int'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, cyc - acc_cyc, FW + 1);
      chk({nm, "_d3"}, int'(d3), x3);
      chk({nm, "_d2"}, int'(d2), x2);
      chk({nm, "_d1"}, int'(d1), x1);
      chk({nm, "_d0"}, int'(d0), x0);
      chk({nm, "_ovf"}, int'(ovf), xov);
    end
  endtask

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_d3", int'(d3), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", int'(in_ready), 1);

    run_case("hhmm_2359", 0, 23, 59, 0, 2, 3, 5, 9, 0);
    run_case("ss_07", 1, 0, 0, 7, BZ, BZ, 0, 7, 0);
    run_case("hhmm_0500", 0, 5, 0, 0, BZ, 5, 0, 0, 0);
    run_case("mmss_0930", 2, 0, 9, 30, BZ, 9, 3, 0, 0);
    run_case("mmss_sat", 2, 0, 120, 45, 9, 9, 4, 5, 1);
    run_case("hhmm_1234", 0, 12, 34, 0, 1, 2, 3, 4, 0);
    run_case("mode3_0847", 3, 8, 47, 11, BZ, 8, 4, 7, 0);

    // in_valid held high: back-to-back accepts, each result a single strobe
    @(negedge clk); #1;
    mode = 2'd0; hour = FW'(1); min = FW'(2); sec = FW'(0);
    in_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        pulses++;
        chk("held_d3", int'(d3), BZ);
        chk("held_d2", int'(d2), 1);
        chk("held_d1", int'(d1), 0);
        chk("held_d0", int'(d0), 2);
      end
    end
    chk("held_pulses", pulses, 3);
    #1 in_valid = 1'b0;
    repeat (12) @(negedge clk);

    // reset three cycles after accept aborts the conversion
    req(0, 23, 59, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    chk("abort_d3", int'(d3), 0);
    chk("abort_d0", int'(d0), 0);
    chk("abort_ovf", int'(ovf), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    run_case("after_abort", 2, 0, 59, 58, 5, 9, 5, 8, 0);

    // randomized stream
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      rst_n    = ($urandom_range(0, 79) != 0);
      in_valid = 1'($urandom_range(0, 1));
      mode     = 2'($urandom_range(0, 3));
      hour     = FW'($urandom_range(0, 127));
      min      = FW'($urandom_range(0, 127));
      sec      = FW'($urandom_range(0, 127));
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
